// File: rtl/sat_pkg.sv
// Shared definitions for the clause BCP scheduler.
// Holds the per-variable value codes, the scheduler state enum and the
// single-variable merge function used by var_merge.
package sat_pkg;

  localparam int unsigned VAL_W = 3;

  // Value code in bits[2:1]; bit[0] is the implied flag.
  typedef enum logic [1:0] {
    FREE  = 2'b00,
    FALSE = 2'b01,
    TRUE  = 2'b10,
    CONFL = 2'b11
  } code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EVAL  = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef struct packed {
    logic [VAL_W-1:0] val;
    logic             changed;
    logic             conflict;
  } merge_t;

  // Fold one clause response into one working variable.
  // A same-polarity response that differs only in the implied flag is kept as-is.
  function automatic merge_t merge_var(input logic [VAL_W-1:0] cur,
                                       input logic [VAL_W-1:0] rsp);
    merge_t m;
    m.val      = cur;
    m.changed  = 1'b0;
    m.conflict = 1'b0;
    if (rsp[2:1] != FREE && rsp != cur) begin
      if (rsp[2:1] == CONFL || (cur[2:1] != FREE && cur[2:1] != rsp[2:1])) begin
        m.val      = {CONFL, cur[0] | rsp[0]};
        m.conflict = 1'b1;
      end else if (cur[2:1] == FREE) begin
        m.val     = rsp;
        m.changed = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/clause_bcp_sched_if.sv
// Clause-array bus of the BCP scheduler.
//   cl_sel_o        one-hot select of the clause under evaluation
//   cl_var_value_o  working assignment broadcast to the selected clause
//   cl_var_value_i  same-cycle response of the selected clause
//   wr_o/wr_data_o  one-hot clause literal write strobe and data
// master = scheduler, slave = clause array.
interface clause_bcp_sched_if #(
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned NUM_CLAUSES = 4
);
  localparam int unsigned VW = NUM_VARS * 3;

  logic [NUM_CLAUSES-1:0] cl_sel_o;
  logic [VW-1:0]          cl_var_value_o;
  logic [VW-1:0]          cl_var_value_i;
  logic [NUM_CLAUSES-1:0] wr_o;
  logic [VW-1:0]          wr_data_o;

  modport master (
    output cl_sel_o, cl_var_value_o, wr_o, wr_data_o,
    input  cl_var_value_i
  );

  modport slave (
    input  cl_sel_o, cl_var_value_o, wr_o, wr_data_o,
    output cl_var_value_i
  );
endinterface

// File: rtl/var_merge.sv
// Per-variable merge of a clause response into the working assignment.
//   cur      current 3-bit value
//   rsp      clause response for this variable
//   nxt      merged value
//   changed  free variable newly assigned
//   conflict disagreement or conflict response seen
module var_merge
  import sat_pkg::*;
(
  input  logic [VAL_W-1:0] cur,
  input  logic [VAL_W-1:0] rsp,
  output logic [VAL_W-1:0] nxt,
  output logic             changed,
  output logic             conflict
);

  merge_t m;

  assign m        = merge_var(cur, rsp);
  assign nxt      = m.val;
  assign changed  = m.changed;
  assign conflict = m.conflict;

endmodule

// File: rtl/clause_bcp_sched.sv
// Boolean constraint propagation scheduler: sweeps the clause slots in order,
// merging each clause response into the working assignment, until fixpoint,
// conflict or round limit.
//   clk, rst            clock, synchronous active-high reset
//   start_i/var_value_i start request and initial assignment (IDLE only)
//   busy_o, done_o      activity level and end-of-run pulse
//   conflict_o/timeout_o result flags, held until the next start
//   var_value_o         working assignment
//   ld_*                clause literal load request, ld_ready_o accept
//   bt_i/apply_backtrack_o backtrack request and its forwarded pulse
//   cb                  clause bus (select, broadcast, response, write)
module clause_bcp_sched
  import sat_pkg::*;
#(
  parameter  int unsigned NUM_VARS    = 8,
  parameter  int unsigned NUM_CLAUSES = 4,
  parameter  int unsigned MAX_ROUNDS  = 16,
  localparam int unsigned CW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [NUM_VARS*3-1:0] var_value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  conflict_o,
  output logic                  timeout_o,
  output logic [NUM_VARS*3-1:0] var_value_o,
  input  logic                  ld_valid_i,
  input  logic [CW-1:0]         ld_idx_i,
  input  logic [NUM_VARS*3-1:0] ld_lits_i,
  output logic                  ld_ready_o,
  input  logic                  bt_i,
  output logic                  apply_backtrack_o,
  clause_bcp_sched_if.master    cb
);

  localparam int unsigned VW = NUM_VARS * 3;
  localparam int unsigned RW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;

  state_t                 state;
  logic [CW-1:0]          ptr;
  logic [RW-1:0]          round;
  logic                   changed_q;
  logic                   conflict_q;
  logic [NUM_CLAUSES-1:0] cl_sel_q;
  logic [NUM_CLAUSES-1:0] wr_q;
  logic [VW-1:0]          wr_data_q;
  logic [VW-1:0]          merged;
  logic [NUM_VARS-1:0]    var_chg;
  logic [NUM_VARS-1:0]    var_cfl;

  // One merge slice per variable against the selected clause's response.
  for (genvar g = 0; g < NUM_VARS; g++) begin : g_merge
    var_merge u_var_merge (
      .cur      (var_value_o[3*g +: 3]),
      .rsp      (cb.cl_var_value_i[3*g +: 3]),
      .nxt      (merged[3*g +: 3]),
      .changed  (var_chg[g]),
      .conflict (var_cfl[g])
    );
  end

  assign ld_ready_o        = (state == IDLE) && !start_i;
  assign cb.cl_sel_o       = cl_sel_q;
  assign cb.cl_var_value_o = var_value_o;
  assign cb.wr_o           = wr_q;
  assign cb.wr_data_o      = wr_data_q;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ptr               <= '0;
      round             <= '0;
      changed_q         <= 1'b0;
      conflict_q        <= 1'b0;
      cl_sel_q          <= '0;
      wr_q              <= '0;
      wr_data_q         <= '0;
      var_value_o       <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      conflict_o        <= 1'b0;
      timeout_o         <= 1'b0;
      apply_backtrack_o <= 1'b0;
    end else begin
      done_o            <= 1'b0;
      wr_q              <= '0;
      apply_backtrack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            var_value_o <= var_value_i;
            ptr         <= '0;
            round       <= '0;
            changed_q   <= 1'b0;
            conflict_q  <= 1'b0;
            conflict_o  <= 1'b0;
            timeout_o   <= 1'b0;
            cl_sel_q    <= NUM_CLAUSES'(1);
            busy_o      <= 1'b1;
            state       <= EVAL;
          end else if (ld_valid_i && (32'(ld_idx_i) < NUM_CLAUSES)) begin
            wr_q      <= NUM_CLAUSES'(1) << ld_idx_i;
            wr_data_q <= ld_lits_i;
          end
          if (bt_i) apply_backtrack_o <= 1'b1;
        end
        EVAL: begin
          var_value_o <= merged;
          if (|var_chg) changed_q  <= 1'b1;
          if (|var_cfl) conflict_q <= 1'b1;
          if (32'(ptr) == NUM_CLAUSES - 1) begin
            cl_sel_q <= '0;
            state    <= CHECK;
          end else begin
            ptr      <= ptr + 1'b1;
            cl_sel_q <= cl_sel_q << 1;
          end
        end
        CHECK: begin
          if (conflict_q || !changed_q) begin
            conflict_o <= conflict_q;
            done_o     <= 1'b1;
            state      <= DONE;
          end else if (32'(round) == MAX_ROUNDS - 1) begin
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            state     <= DONE;
          end else begin
            round     <= round + 1'b1;
            changed_q <= 1'b0;
            ptr       <= '0;
            cl_sel_q  <= NUM_CLAUSES'(1);
            state     <= EVAL;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_bcp_sched.sv
// Self-checking bench for clause_bcp_sched: directed vector table, hand
// sequences for load/backtrack/reset, and randomized runs against a
// sweep-level reference model. Two DUTs share inputs: MAX_ROUNDS 16 and 2.
module tb_clause_bcp_sched;

  localparam int NV = 8;
  localparam int NC = 4;
  localparam int VW = NV * 3;

  localparam int SC_ID    = 0;
  localparam int SC_CHAIN = 1;
  localparam int SC_CONF  = 2;
  localparam int SC_STEP  = 3;
  localparam int SC_RAND  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] var_in;
  logic          ld_valid;
  logic [1:0]    ld_idx;
  logic [VW-1:0] ld_lits;
  logic          bt;

  logic          busy_m, done_m, cfl_m, to_m, ldr_m, abt_m;
  logic          busy_s, done_s, cfl_s, to_s, ldr_s, abt_s;
  logic [VW-1:0] vout_m, vout_s;

  int scen;
  logic [VW-1:0] rtab [NC];
  logic [NV-1:0] gate [NC];

  int n_cmp = 0;
  int n_bad = 0;

  logic [VW-1:0] r_vars [2];
  bit            r_cfl  [2];
  bit            r_to   [2];
  int            r_lat  [2];
  int            r_nd   [2];

  always #5 clk = ~clk;

  clause_bcp_sched_if #(.NUM_VARS(NV), .NUM_CLAUSES(NC)) cb_m ();
  clause_bcp_sched_if #(.NUM_VARS(NV), .NUM_CLAUSES(NC)) cb_s ();

  clause_bcp_sched #(.NUM_VARS(NV), .NUM_CLAUSES(NC), .MAX_ROUNDS(16)) u_m (
    .clk(clk), .rst(rst), .start_i(start), .var_value_i(var_in),
    .busy_o(busy_m), .done_o(done_m), .conflict_o(cfl_m), .timeout_o(to_m),
    .var_value_o(vout_m), .ld_valid_i(ld_valid), .ld_idx_i(ld_idx),
    .ld_lits_i(ld_lits), .ld_ready_o(ldr_m), .bt_i(bt),
    .apply_backtrack_o(abt_m), .cb(cb_m)
  );

  clause_bcp_sched #(.NUM_VARS(NV), .NUM_CLAUSES(NC), .MAX_ROUNDS(2)) u_s (
    .clk(clk), .rst(rst), .start_i(start), .var_value_i(var_in),
    .busy_o(busy_s), .done_o(done_s), .conflict_o(cfl_s), .timeout_o(to_s),
    .var_value_o(vout_s), .ld_valid_i(ld_valid), .ld_idx_i(ld_idx),
    .ld_lits_i(ld_lits), .ld_ready_o(ldr_s), .bt_i(bt),
    .apply_backtrack_o(abt_s), .cb(cb_s)
  );

  function automatic int sel_idx(input logic [NC-1:0] s);
    int k = -1;
    for (int i = NC - 1; i >= 0; i--) if (s[i]) k = i;
    return k;
  endfunction

  // Behaviour of the external clause array for each scenario.
  function automatic logic [VW-1:0] clause_resp(input int sc, input int ci,
                                                input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic [2:0]    e;
    bit            found;
    int            k;
    r = v;
    found = 1'b0;
    case (sc)
      SC_CHAIN: begin
        if (ci == 2 && v[11:10] == 2'b00) r[11:9] = 3'b101;
        if (ci == 0 && v[11:10] != 2'b00 && v[17:16] == 2'b00) r[17:15] = 3'b011;
      end
      SC_CONF: if (ci == 1) r[5:3] = 3'b011;
      SC_STEP: begin
        if (ci == 0)
          for (int j = 0; j < NV; j++)
            if (!found && v[3*j+1 +: 2] == 2'b00) begin
              r[3*j +: 3] = 3'b101;
              found = 1'b1;
            end
      end
      SC_RAND: begin
        if (ci >= 0)
          for (int j = 0; j < NV; j++) begin
            e = rtab[ci][3*j +: 3];
            k = (j + NV - 1) % NV;
            if (e[2:1] != 2'b00 && (gate[ci][j] || v[3*k+1 +: 2] != 2'b00))
              r[3*j +: 3] = e;
          end
      end
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb cb_m.cl_var_value_i = clause_resp(scen, sel_idx(cb_m.cl_sel_o), cb_m.cl_var_value_o);
  always_comb cb_s.cl_var_value_i = clause_resp(scen, sel_idx(cb_s.cl_sel_o), cb_s.cl_var_value_o);

  // Sweep-level reference: each sweep is NC evaluations plus one check cycle.
  task automatic model_run(input logic [VW-1:0] init, input int sc, input int mr,
                           output logic [VW-1:0] vo, output bit cfl,
                           output bit to, output int lat);
    logic [VW-1:0] v, rsp;
    int  cp, rp, sweeps;
    bit  chg, stop;
    v = init; cfl = 1'b0; to = 1'b0; sweeps = 0; stop = 1'b0;
    for (int rnd = 0; rnd < mr && !stop; rnd++) begin
      chg = 1'b0;
      for (int c = 0; c < NC; c++) begin
        rsp = clause_resp(sc, c, v);
        for (int j = 0; j < NV; j++) begin
          cp = int'(v[3*j+1 +: 2]);
          rp = int'(rsp[3*j+1 +: 2]);
          if (rp != 0 && rsp[3*j +: 3] != v[3*j +: 3]) begin
            if (rp == 3 || (cp != 0 && cp != rp)) begin
              v[3*j +: 3] = {2'b11, v[3*j] | rsp[3*j]};
              cfl = 1'b1;
            end else if (cp == 0) begin
              v[3*j +: 3] = rsp[3*j +: 3];
              chg = 1'b1;
            end
          end
        end
      end
      sweeps++;
      if (cfl || !chg) stop = 1'b1;
      else if (rnd == mr - 1) begin to = 1'b1; stop = 1'b1; end
    end
    vo  = v;
    lat = 1 + sweeps * (NC + 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_m || busy_s) && n < 400) begin tick(); n++; end
    if (n >= 400) chk("idle_budget", 32'(n), 32'(0));
  endtask

  // Start one run on both DUTs and record each DUT's done pulse and results.
  task automatic do_run(input logic [VW-1:0] init, input int sc, input bit chk_seq);
    int cyc = 0;
    bit fin = 1'b0;
    scen = sc; var_in = init; start = 1'b1;
    r_nd[0] = 0; r_nd[1] = 0; r_lat[0] = 0; r_lat[1] = 0;
    while (!fin && cyc < 400) begin
      tick();
      start = 1'b0;
      cyc++;
      if (chk_seq && cyc == 1) chk("busy_after_start", 32'(busy_m), 32'(1));
      if (chk_seq && cyc <= NC) chk($sformatf("cl_sel_eval%0d", cyc), 32'(cb_m.cl_sel_o), 32'(1) << (cyc - 1));
      if (chk_seq && cyc == 2) chk("broadcast", 32'(cb_m.cl_var_value_o), 32'(vout_m));
      if (chk_seq && cyc == NC + 1) chk("cl_sel_check", 32'(cb_m.cl_sel_o), 32'(0));
      if (done_m) begin r_nd[0]++; r_lat[0] = cyc; r_vars[0] = vout_m; r_cfl[0] = cfl_m; r_to[0] = to_m; end
      if (done_s) begin r_nd[1]++; r_lat[1] = cyc; r_vars[1] = vout_s; r_cfl[1] = cfl_s; r_to[1] = to_s; end
      if (!busy_m && !busy_s) fin = 1'b1;
    end
    if (!fin) chk("run_budget", 32'(cyc), 32'(0));
  endtask

  task automatic chk_res(input string tag, input int d, input logic [VW-1:0] ev,
                         input bit ec, input bit et, input int el);
    chk({tag, "_latency"}, 32'(r_lat[d]), 32'(el));
    chk({tag, "_done_pulses"}, 32'(r_nd[d]), 32'(1));
    chk({tag, "_vars"}, 32'(r_vars[d]), 32'(ev));
    chk({tag, "_conflict"}, 32'(r_cfl[d]), 32'(ec));
    chk({tag, "_timeout"}, 32'(r_to[d]), 32'(et));
  endtask

  typedef struct {
    int            dut;
    int            sc;
    logic [VW-1:0] init;
    logic [VW-1:0] exp_vars;
    bit            exp_cfl;
    bit            exp_to;
    int            exp_lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [VW-1:0] mv;
    bit            mc, mt;
    int            ml;

    tbl[0] = '{0, SC_ID,    24'h000000, 24'h000000, 1'b0, 1'b0, 6};
    tbl[1] = '{0, SC_CHAIN, 24'h000000, 24'h018A00, 1'b0, 1'b0, 16};
    tbl[2] = '{0, SC_CONF,  24'h000020, 24'h000038, 1'b1, 1'b0, 6};
    tbl[3] = '{0, SC_CONF,  24'h000000, 24'h000018, 1'b0, 1'b0, 11};
    tbl[4] = '{1, SC_STEP,  24'h000000, 24'h00002D, 1'b0, 1'b1, 11};
    tbl[5] = '{0, SC_STEP,  24'h000000, 24'hB6DB6D, 1'b0, 1'b0, 46};

    scen = SC_ID; start = 1'b0; var_in = '0; ld_valid = 1'b0; ld_idx = '0;
    ld_lits = '0; bt = 1'b0; rst = 1'b1;
    for (int i = 0; i < NC; i++) begin rtab[i] = '0; gate[i] = '0; end
    tick(); tick();

    chk("rst_busy", 32'(busy_m), 32'(0));
    chk("rst_done", 32'(done_m), 32'(0));
    chk("rst_vars", 32'(vout_m), 32'(0));
    chk("rst_cl_sel", 32'(cb_m.cl_sel_o), 32'(0));
    chk("rst_wr", 32'(cb_m.wr_o), 32'(0));
    chk("rst_flags", {30'd0, cfl_m, to_m}, 32'(0));
    chk("rst_abt", 32'(abt_m), 32'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_run(tbl[i].init, tbl[i].sc, i == 0);
      chk_res($sformatf("vec%0d", i), tbl[i].dut, tbl[i].exp_vars,
              tbl[i].exp_cfl, tbl[i].exp_to, tbl[i].exp_lat);
    end

    // Clause loads in IDLE: one-cycle one-hot strobe with data.
    for (int i = 0; i < NC; i++) begin
      chk("ld_ready_idle", 32'(ldr_m), 32'(1));
      ld_valid = 1'b1; ld_idx = 2'(i); ld_lits = 24'($urandom);
      mv = ld_lits;
      tick();
      ld_valid = 1'b0;
      chk($sformatf("wr_strobe%0d", i), 32'(cb_m.wr_o), 32'(1) << i);
      chk($sformatf("wr_data%0d", i), 32'(cb_m.wr_data_o), 32'(mv));
      tick();
      chk("wr_pulse_end", 32'(cb_m.wr_o), 32'(0));
    end

    // Start and load together: start wins, no write.
    scen = SC_ID; var_in = '0; start = 1'b1; ld_valid = 1'b1; ld_idx = 2'd2;
    #1;
    chk("ld_ready_with_start", 32'(ldr_m), 32'(0));
    tick();
    start = 1'b0; ld_valid = 1'b0;
    chk("wr_blocked_by_start", 32'(cb_m.wr_o), 32'(0));
    chk("busy_on_start", 32'(busy_m), 32'(1));
    wait_idle();

    // Backtrack in IDLE forwards a single pulse.
    bt = 1'b1;
    tick();
    bt = 1'b0;
    chk("bt_pulse", 32'(abt_m), 32'(1));
    tick();
    chk("bt_pulse_end", 32'(abt_m), 32'(0));

    // Backtrack and load while busy are ignored.
    start = 1'b1; var_in = '0; scen = SC_ID;
    tick();
    start = 1'b0; bt = 1'b1; ld_valid = 1'b1; ld_idx = 2'd1;
    tick();
    bt = 1'b0; ld_valid = 1'b0;
    chk("bt_busy_ignored", 32'(abt_m), 32'(0));
    chk("ld_busy_ignored", 32'(cb_m.wr_o), 32'(0));
    chk("ld_ready_busy", 32'(ldr_m), 32'(0));
    wait_idle();

    // Reset while evaluating clause 2.
    var_in = 24'h00A5A5; scen = SC_ID; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("pre_rst_cl_sel", 32'(cb_m.cl_sel_o), 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy_m), 32'(0));
    chk("midrst_cl_sel", 32'(cb_m.cl_sel_o), 32'(0));
    chk("midrst_vars", 32'(vout_m), 32'(0));
    do_run(24'h000000, SC_ID, 1'b0);
    chk_res("post_rst", 0, 24'h000000, 1'b0, 1'b0, 6);

    // Randomized clause behaviour against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < NC; c++) begin
        gate[c] = 8'($urandom);
        for (int j = 0; j < NV; j++) begin
          case ($urandom_range(0, 9))
            6, 7:    rtab[c][3*j +: 3] = {2'b01, 1'($urandom)};
            8, 9:    rtab[c][3*j +: 3] = {2'b10, 1'($urandom)};
            default: rtab[c][3*j +: 3] = 3'b000;
          endcase
        end
      end
      for (int j = 0; j < NV; j++) begin
        case ($urandom_range(0, 15))
          8, 9, 10:   mv[3*j +: 3] = {2'b01, 1'($urandom)};
          11, 12, 13: mv[3*j +: 3] = {2'b10, 1'($urandom)};
          14:         mv[3*j +: 3] = {2'b11, 1'($urandom)};
          default:    mv[3*j +: 3] = 3'b000;
        endcase
      end
      var_in = mv;
      do_run(mv, SC_RAND, 1'b0);
      model_run(var_in, SC_RAND, 16, mv, mc, mt, ml);
      chk_res($sformatf("rnd%0d_m", it), 0, mv, mc, mt, ml);
      model_run(var_in, SC_RAND, 2, mv, mc, mt, ml);
      chk_res($sformatf("rnd%0d_s", it), 1, mv, mc, mt, ml);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
